// File: rtl/bconv_layer_sched.sv
// rtl/bconv_layer_sched.sv - layer/channel sequencer for the binary 3x3 conv engine and line buffer
module bconv_layer_sched #(
    parameter int NCH_L0   = 6,
    parameter int NCH_L1   = 16,
    parameter int WADDR_W  = 10,
    parameter int WIN_LEAD = 1,
    parameter int TIMEOUT  = 4095
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_go,
    input  logic               i_abort,
    output logic               o_wmem_rd,
    output logic [WADDR_W-1:0] o_wmem_addr,
    input  logic               i_wmem_data,
    output logic               o_weight_en,
    output logic               o_weight,
    output logic               o_win_start,
    output logic               o_conv_start,
    output logic               o_layer_sel,
    input  logic               i_conv_ovalid,
    input  logic               i_conv_done,
    output logic               o_busy,
    output logic [4:0]         o_ch_idx,
    output logic               o_all_done,
    output logic [7:0]         o_err_cnt,
    output logic               o_timeout_err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADW,
        S_ARM,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [3:0]         r_j;
    logic [3:0]         r_lead;
    logic [TMO_W-1:0]   r_tmo;
    logic [9:0]         r_ovcnt;
    logic [4:0]         r_ch;
    logic               r_layer;
    logic               r_fin;
    logic [7:0]         r_err;
    logic               r_timeout_err;
    logic               r_wmem_rd;
    logic [WADDR_W-1:0] r_wmem_addr;
    logic               r_weight_en;
    logic               r_wvalid;
    logic               r_win_start;
    logic               r_conv_start;
    logic               r_all_done;

    logic [9:0]         w_ovcnt_nxt;
    logic [9:0]         w_ov_exp;
    logic [4:0]         w_ch_last;
    logic [WADDR_W-1:0] w_base;
    logic [7:0]         w_err_inc;

    // The ovalid arriving together with conv_done belongs to this channel, so the check uses the incremented count.
    assign w_ovcnt_nxt = r_ovcnt + {9'd0, i_conv_ovalid};
    assign w_ov_exp    = r_layer ? 10'd100 : 10'd676;
    assign w_ch_last   = r_layer ? 5'(NCH_L1 - 1) : 5'(NCH_L0 - 1);
    assign w_base      = r_layer ? WADDR_W'(NCH_L0 * 9 + int'(r_ch) * 9) : WADDR_W'(int'(r_ch) * 9);
    assign w_err_inc   = (r_err == 8'hFF) ? r_err : r_err + 8'd1;

    // Weight memory has one cycle of read latency; r_wvalid marks the cycles whose data answers our own read.
    assign o_weight      = r_wvalid & i_wmem_data;
    assign o_wmem_rd     = r_wmem_rd;
    assign o_wmem_addr   = r_wmem_addr;
    assign o_weight_en   = r_weight_en;
    assign o_win_start   = r_win_start;
    assign o_conv_start  = r_conv_start;
    assign o_layer_sel   = r_layer;
    assign o_busy        = (r_state != S_IDLE);
    assign o_ch_idx      = r_ch;
    assign o_all_done    = r_all_done;
    assign o_err_cnt     = r_err;
    assign o_timeout_err = r_timeout_err;

    // Sequencer: state, counters and all registered strobes/enables.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_j           <= '0;
            r_lead        <= '0;
            r_tmo         <= '0;
            r_ovcnt       <= '0;
            r_ch          <= '0;
            r_layer       <= 1'b0;
            r_fin         <= 1'b0;
            r_err         <= '0;
            r_timeout_err <= 1'b0;
            r_wmem_rd     <= 1'b0;
            r_wmem_addr   <= '0;
            r_weight_en   <= 1'b0;
            r_wvalid      <= 1'b0;
            r_win_start   <= 1'b0;
            r_conv_start  <= 1'b0;
            r_all_done    <= 1'b0;
        end else begin
            r_all_done <= 1'b0;
            r_wvalid   <= r_wmem_rd;
            if (i_abort) begin
                r_state      <= S_IDLE;
                r_wmem_rd    <= 1'b0;
                r_weight_en  <= 1'b0;
                r_wvalid     <= 1'b0;
                r_win_start  <= 1'b0;
                r_conv_start <= 1'b0;
                r_fin        <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_go) begin
                            r_state       <= S_LOADW;
                            r_j           <= '0;
                            r_ch          <= '0;
                            r_layer       <= 1'b0;
                            r_fin         <= 1'b0;
                            r_timeout_err <= 1'b0;
                            r_wmem_rd     <= 1'b1;
                            r_wmem_addr   <= '0;
                            r_weight_en   <= 1'b1;
                        end
                    end
                    S_LOADW: begin
                        if (r_j == 4'd9) begin
                            // Dropping weight_en here lets the engine clear its weight address counter.
                            r_weight_en <= 1'b0;
                            r_win_start <= 1'b1;
                            if (WIN_LEAD == 0) begin
                                r_state      <= S_RUN;
                                r_conv_start <= 1'b1;
                                r_ovcnt      <= '0;
                                r_tmo        <= '0;
                            end else begin
                                r_state <= S_ARM;
                                r_lead  <= '0;
                            end
                        end else begin
                            r_j       <= r_j + 4'd1;
                            r_wmem_rd <= (r_j < 4'd8);
                            if (r_j < 4'd8) begin
                                r_wmem_addr <= r_wmem_addr + WADDR_W'(1);
                            end
                        end
                    end
                    S_ARM: begin
                        if (r_lead == 4'(WIN_LEAD - 1)) begin
                            r_state      <= S_RUN;
                            r_conv_start <= 1'b1;
                            r_ovcnt      <= '0;
                            r_tmo        <= '0;
                        end else begin
                            r_lead <= r_lead + 4'd1;
                        end
                    end
                    S_RUN: begin
                        r_ovcnt <= w_ovcnt_nxt;
                        if (i_conv_done) begin
                            if (w_ovcnt_nxt != w_ov_exp) begin
                                r_err <= w_err_inc;
                            end
                            r_state      <= S_NEXT;
                            r_win_start  <= 1'b0;
                            r_conv_start <= 1'b0;
                            // Channel/layer advance becomes visible in NEXT, while every enable is low.
                            if (r_ch == w_ch_last) begin
                                r_ch <= '0;
                                if (r_layer) begin
                                    r_layer <= 1'b0;
                                    r_fin   <= 1'b1;
                                end else begin
                                    r_layer <= 1'b1;
                                end
                            end else begin
                                r_ch <= r_ch + 5'd1;
                            end
                        end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                            r_err         <= w_err_inc;
                            r_timeout_err <= 1'b1;
                            r_state       <= S_IDLE;
                            r_win_start   <= 1'b0;
                            r_conv_start  <= 1'b0;
                        end else begin
                            r_tmo <= r_tmo + TMO_W'(1);
                        end
                    end
                    S_NEXT: begin
                        if (r_fin) begin
                            r_state    <= S_DONE;
                            r_fin      <= 1'b0;
                            r_all_done <= 1'b1;
                        end else begin
                            r_state     <= S_LOADW;
                            r_j         <= '0;
                            r_wmem_rd   <= 1'b1;
                            r_wmem_addr <= w_base;
                            r_weight_en <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bconv_layer_sched.sv
// tb/tb_bconv_layer_sched.sv - self-checking bench for bconv_layer_sched
module tb_bconv_layer_sched;

    localparam int L0  = 2;
    localparam int L1  = 2;
    localparam int NCH = L0 + L1;

    typedef struct {
        logic [3:0] mask;
        int         delta;
        bit         gaps;
        bit         rand_mem;
        bit         early_done;
        int         exp_err_inc;
        int         exp_done;
    } vec_t;

    logic       clk;
    logic       rstn;
    logic       go, abort, wmem_rd, wdata, weight_en, weight, win_start, conv_start, layer_sel;
    logic       ovalid, done, busy, all_done, timeout_err;
    logic [9:0] waddr;
    logic [4:0] ch_idx;
    logic [7:0] err_cnt;
    logic       t_go, t_abort, t_wmem_rd, t_wdata, t_weight_en, t_weight, t_win_start, t_conv_start, t_layer_sel;
    logic       t_ovalid, t_done, t_busy, t_all_done, t_timeout_err;
    logic [9:0] t_waddr;
    logic [4:0] t_ch_idx;
    logic [7:0] t_err;

    int checks = 0;
    int failures = 0;
    int model_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bconv_layer_sched #(.NCH_L0(L0), .NCH_L1(L1), .WADDR_W(10), .WIN_LEAD(1), .TIMEOUT(4095)) u_dut (
        .clk(clk), .rstn(rstn), .i_go(go), .i_abort(abort), .o_wmem_rd(wmem_rd), .o_wmem_addr(waddr),
        .i_wmem_data(wdata), .o_weight_en(weight_en), .o_weight(weight), .o_win_start(win_start),
        .o_conv_start(conv_start), .o_layer_sel(layer_sel), .i_conv_ovalid(ovalid), .i_conv_done(done),
        .o_busy(busy), .o_ch_idx(ch_idx), .o_all_done(all_done), .o_err_cnt(err_cnt), .o_timeout_err(timeout_err)
    );

    bconv_layer_sched #(.NCH_L0(L0), .NCH_L1(L1), .WADDR_W(10), .WIN_LEAD(1), .TIMEOUT(50)) u_tmo (
        .clk(clk), .rstn(rstn), .i_go(t_go), .i_abort(t_abort), .o_wmem_rd(t_wmem_rd), .o_wmem_addr(t_waddr),
        .i_wmem_data(t_wdata), .o_weight_en(t_weight_en), .o_weight(t_weight), .o_win_start(t_win_start),
        .o_conv_start(t_conv_start), .o_layer_sel(t_layer_sel), .i_conv_ovalid(t_ovalid), .i_conv_done(t_done),
        .o_busy(t_busy), .o_ch_idx(t_ch_idx), .o_all_done(t_all_done), .o_err_cnt(t_err), .o_timeout_err(t_timeout_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Weight memory: 1-bit words, data valid the cycle after a read strobe, junk otherwise.
    logic       mem [0:63];
    logic       m_rd;
    logic [9:0] m_a;
    initial begin
        wdata = 1'b0;
        forever begin
            @(negedge clk);
            m_rd = wmem_rd;
            m_a  = waddr;
            @(posedge clk);
            #1;
            if (m_rd) wdata = (m_a < 10'd64) ? mem[m_a[5:0]] : 1'b0;
            else      wdata = 1'($urandom);
        end
    end

    // Engine model: emits ovalids while conv_start is high, done together with the Nth ovalid.
    logic [3:0] cur_mask;
    int         cur_delta;
    bit         gap_en;
    bit         force_done;
    bit         e_active;
    int         e_cnt, e_target, e_k;
    initial begin
        ovalid = 1'b0; done = 1'b0; e_active = 0; e_cnt = 0; e_target = 0; e_k = 0;
        forever begin
            @(negedge clk);
            if (force_done) begin
                ovalid = 1'b1; done = 1'b1;
            end else if (conv_start) begin
                if (!e_active) begin
                    e_active = 1; e_cnt = 0;
                    e_k = int'(layer_sel) * L0 + int'(ch_idx);
                    e_target = (layer_sel ? 100 : 676) + ((e_k < 4 && cur_mask[e_k & 3]) ? cur_delta : 0);
                end
                ovalid = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (ovalid) e_cnt++;
                done = ovalid && (e_cnt == e_target);
            end else begin
                e_active = 0; ovalid = 1'b0; done = 1'b0;
            end
        end
    end

    // Observer: records the interface activity of u_dut for comparison after each run.
    int   q_addr[$];
    logic q_w[$];
    int   q_welen[$];
    int   q_run[$];
    int   q_lead[$];
    int   we_len, lead, viol, n_done;
    logic p_cs, p_ls;
    bit   mon_clr;
    initial begin
        we_len = 0; lead = 0; viol = 0; n_done = 0; p_cs = 1'b0; p_ls = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_clr) begin
                q_addr.delete(); q_w.delete(); q_welen.delete(); q_run.delete(); q_lead.delete();
                we_len = 0; lead = 0; viol = 0; n_done = 0; p_cs = conv_start; p_ls = layer_sel;
            end else begin
                if (wmem_rd) q_addr.push_back(int'(waddr));
                if (weight_en) begin
                    q_w.push_back(weight); we_len++;
                end else if (we_len != 0) begin
                    q_welen.push_back(we_len); we_len = 0;
                end
                if (conv_start && !p_cs) begin
                    q_run.push_back(int'({layer_sel, ch_idx}));
                    q_lead.push_back(lead);
                end
                if (win_start && !conv_start) lead++;
                else if (!win_start) lead = 0;
                if (conv_start && !win_start) viol++;
                if (weight_en && (win_start || conv_start)) viol++;
                if ((win_start || conv_start || weight_en) && (layer_sel !== p_ls)) viol++;
                if (all_done) n_done++;
                p_cs = conv_start; p_ls = layer_sel;
            end
        end
    end

    task automatic mon_reset();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    // One full go-to-idle sequence on u_dut, then compare against what the rules say should have happened.
    task automatic do_run(input vec_t v);
        int         c, bad, idx;
        logic       e;
        logic [8:0] pat;
        logic [9:0] wseq;
        mon_reset();
        cur_mask = v.mask; cur_delta = v.delta; gap_en = v.gaps;
        for (int i = 0; i < 64; i++) mem[i] = 1'($urandom);
        pat = 9'b101101001;
        if (!v.rand_mem) for (int i = 0; i < 9; i++) mem[i] = pat[8 - i];
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        c = 0;
        while (busy && c < 8000) begin
            @(negedge clk);
            c++;
            go = (c == 300);
            force_done = v.early_done && (c < 6);
        end
        go = 1'b0; force_done = 0;
        model_err = model_err + v.exp_err_inc;
        if (model_err > 255) model_err = 255;
        chk("run_returns_idle", busy, 0);
        chk("addr_count", q_addr.size(), NCH * 9);
        bad = 0;
        for (int i = 0; i < q_addr.size(); i++) if (q_addr[i] != i) bad++;
        chk("addr_seq_bad", bad, 0);
        chk("weight_count", q_w.size(), NCH * 10);
        bad = 0;
        for (int k = 0; k < NCH; k++)
            for (int j = 0; j < 10; j++) begin
                idx = k * 10 + j;
                e = (j == 0) ? 1'b0 : mem[k * 9 + j - 1];
                if (idx < q_w.size() && q_w[idx] !== e) bad++;
            end
        chk("weight_bits_bad", bad, 0);
        if (!v.rand_mem) begin
            wseq = '0;
            for (int i = 0; i < 10; i++) wseq = {wseq[8:0], (i < q_w.size()) ? q_w[i] : 1'b0};
            chk("weight_seq_ch0", wseq, 10'b0101101001);
        end
        chk("weight_en_windows", q_welen.size(), NCH);
        bad = 0;
        foreach (q_welen[i]) if (q_welen[i] != 10) bad++;
        chk("weight_en_len_bad", bad, 0);
        chk("run_windows", q_run.size(), NCH);
        bad = 0;
        for (int k = 0; k < NCH && k < q_run.size(); k++) if (q_run[k] != (k / L0) * 32 + (k % L0)) bad++;
        chk("run_layer_ch_bad", bad, 0);
        bad = 0;
        foreach (q_lead[i]) if (q_lead[i] != 1) bad++;
        chk("win_lead_bad", bad, 0);
        chk("enable_rule_violations", viol, 0);
        chk("all_done_pulses", n_done, v.exp_done);
        chk("err_cnt", err_cnt, model_err);
        chk("timeout_err_clear", timeout_err, 0);
    endtask

    // One go on u_tmo with an engine that never finishes.
    task automatic tmo_once(output int run_cyc, output int ad, output logic te_after_go);
        int c;
        run_cyc = 0; ad = 0; c = 0;
        t_wdata = 1'($urandom);
        @(negedge clk); t_go = 1'b1;
        @(negedge clk); t_go = 1'b0;
        te_after_go = t_timeout_err;
        while (t_busy && c < 200) begin
            if (t_conv_start) run_cyc++;
            if (t_all_done) ad++;
            t_ovalid = 1'($urandom);
            @(negedge clk);
            c++;
        end
    endtask

    vec_t vtab[4];
    vec_t vr;
    int   rc, ad, c, d;
    logic te;

    initial begin
        vtab[0] = '{4'b0000,  0, 1'b0, 1'b0, 1'b0, 0, 1};
        vtab[1] = '{4'b0010, -1, 1'b1, 1'b1, 1'b0, 1, 1};
        vtab[2] = '{4'b1001,  1, 1'b1, 1'b1, 1'b1, 2, 1};
        vtab[3] = '{4'b1111, -3, 1'b1, 1'b1, 1'b0, 4, 1};

        rstn = 1'b0; go = 1'b0; abort = 1'b0; force_done = 0; mon_clr = 1'b0;
        cur_mask = '0; cur_delta = 0; gap_en = 0;
        t_go = 1'b0; t_abort = 1'b0; t_ovalid = 1'b0; t_done = 1'b0; t_wdata = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {wmem_rd, waddr, weight_en, weight, win_start, conv_start, layer_sel, busy, ch_idx, all_done, err_cnt, timeout_err}, 0);
        chk("reset_outputs_tmo", {t_wmem_rd, t_waddr, t_weight_en, t_win_start, t_conv_start, t_busy, t_all_done, t_err, t_timeout_err}, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_after_reset_busy", busy, 0);

        // Timeout path and err_cnt saturation on the short-timeout instance.
        tmo_once(rc, ad, te);
        chk("tmo_run_cycles", rc, 50);
        chk("tmo_timeout_err", t_timeout_err, 1);
        chk("tmo_err_cnt", t_err, 1);
        chk("tmo_busy", t_busy, 0);
        chk("tmo_no_all_done", ad, 0);
        tmo_once(rc, ad, te);
        chk("tmo_err_cleared_on_go", te, 0);
        chk("tmo_err_cnt_2", t_err, 2);
        for (int n = 3; n <= 256; n++) begin
            tmo_once(rc, ad, te);
            if (n == 254) chk("tmo_err_cnt_254", t_err, 254);
        end
        chk("tmo_err_cnt_saturated", t_err, 255);

        // Table rows, then randomized rows.
        for (int r = 0; r < 4; r++) do_run(vtab[r]);
        for (int r = 0; r < 2; r++) begin
            d = $urandom_range(1, 2);
            if ($urandom_range(0, 1) == 1) d = -d;
            vr = '{4'($urandom), d, 1'b1, 1'b1, 1'b0, 0, 1};
            vr.exp_err_inc = $countones(vr.mask);
            do_run(vr);
        end

        // conv_done while idle is ignored.
        force_done = 1;
        repeat (3) @(negedge clk);
        force_done = 0;
        @(negedge clk);
        chk("idle_done_ignored_err", err_cnt, model_err);
        chk("idle_done_ignored_busy", busy, 0);

        // Abort during weight load at j=4, then a clean restart from address 0.
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_pre_weight_en", weight_en, 1);
        chk("abort_pre_addr", waddr, 4);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_weight_en", weight_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_wmem_rd", wmem_rd, 0);
        chk("abort_err_kept", err_cnt, model_err);
        do_run(vtab[0]);

        // go and abort together: abort wins.
        @(negedge clk); go = 1'b1; abort = 1'b1;
        @(negedge clk); go = 1'b0; abort = 1'b0;
        chk("go_abort_busy", busy, 0);
        chk("go_abort_weight_en", weight_en, 0);

        // Asynchronous reset during a layer-1 run.
        cur_mask = '0; cur_delta = 0; gap_en = 1;
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        c = 0;
        while (!(layer_sel && conv_start) && c < 8000) begin
            @(negedge clk);
            c++;
        end
        chk("reached_layer1_run", layer_sel & conv_start, 1);
        repeat (20) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("rst_conv_start", conv_start, 0);
        chk("rst_win_start", win_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_cnt", err_cnt, 0);
        @(negedge clk); rstn = 1'b1;
        model_err = 0;
        do_run(vtab[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
